// File: rtl/downstream_cancel_tracker_pkg.sv
// Shared types and sizing for the downstream cancel tracker.
//   cancel_msg_t : latched cancel/reinstate message
//   CANCEL_ADD/CANCEL_SUB : encodings of in_kind
//   N_CLIENTS, ID_W, AMT_W, CNT_W : table geometry and datapath widths
package downstream_cancel_tracker_pkg;
  localparam int N_CLIENTS = 32;
  localparam int ID_W      = 5;
  localparam int AMT_W     = 16;
  localparam int CNT_W     = 32;

  localparam logic CANCEL_ADD = 1'b0;
  localparam logic CANCEL_SUB = 1'b1;

  typedef struct packed {
    logic [ID_W-1:0]  client_id;
    logic [AMT_W-1:0] amount;
    logic             kind;
  } cancel_msg_t;
endpackage

// File: rtl/downstream_cancel_tracker_if.sv
// Message, lookup and status bundle of the cancel tracker.
//   master : message source / risk-check side
//   slave  : the tracker itself
interface downstream_cancel_tracker_if;
  import downstream_cancel_tracker_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ID_W-1:0]  in_client_id;
  logic [AMT_W-1:0] in_amount;
  logic             in_kind;
  logic             clear_all;
  logic [ID_W-1:0]  rd_client_id;
  logic [CNT_W-1:0] rd_cancelled;
  logic             upd_valid;
  logic [ID_W-1:0]  upd_client_id;
  logic [CNT_W-1:0] upd_total;
  logic             sat_err;
  logic             underflow_err;
  logic             busy;

  modport master (
    output in_valid, in_client_id, in_amount, in_kind, clear_all, rd_client_id,
    input  in_ready, rd_cancelled, upd_valid, upd_client_id, upd_total,
           sat_err, underflow_err, busy
  );

  modport slave (
    input  in_valid, in_client_id, in_amount, in_kind, clear_all, rd_client_id,
    output in_ready, rd_cancelled, upd_valid, upd_client_id, upd_total,
           sat_err, underflow_err, busy
  );
endinterface

// File: rtl/downstream_cancel_tracker_table.sv
// cancel_table_ram: N_CLIENTS x CNT_W table.
//   clk, rst           : clock, sync active-high reset of the read registers only
//   we/waddr/wdata     : single write port
//   re_a/raddr_a/rdata_a : registered read used by the RMW READ state
//   raddr_b/rdata_b    : registered lookup, write-first on address match
module cancel_table_ram
  import downstream_cancel_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ID_W-1:0]  waddr,
  input  logic [CNT_W-1:0] wdata,
  input  logic             re_a,
  input  logic [ID_W-1:0]  raddr_a,
  output logic [CNT_W-1:0] rdata_a,
  input  logic [ID_W-1:0]  raddr_b,
  output logic [CNT_W-1:0] rdata_b
);
  logic [CNT_W-1:0] mem [N_CLIENTS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Port A is never read in a cycle that writes, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (rst)       rdata_a <= '0;
    else if (re_a) rdata_a <= mem[raddr_a];
  end

  always_ff @(posedge clk) begin
    if (rst)                         rdata_b <= '0;
    else if (we && waddr == raddr_b) rdata_b <= wdata;
    else                             rdata_b <= mem[raddr_b];
  end
endmodule

// File: rtl/downstream_cancel_tracker.sv
// Per-client cancelled-quantity accumulator.
//   clk    : clock
//   HRESET : sync active-high reset; starts a full table sweep
//   bus    : message handshake, clear_all, lookup port, update pulse and flags
// Messages are handled as READ then WRITE of one table entry; a new message
// may be accepted in WRITE so its READ sees the committed value.
module downstream_cancel_tracker
  import downstream_cancel_tracker_pkg::*;
(
  input  logic                          clk,
  input  logic                          HRESET,
  downstream_cancel_tracker_if.slave    bus
);
  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0]       state;
  logic [ID_W-1:0]  clr_cnt;
  cancel_msg_t      msg;
  logic             sat_err, underflow_err;

  logic [CNT_W-1:0] old_val, amt_z, new_val;
  logic [CNT_W:0]   sum;
  logic             ovf, unf;
  logic             in_ready, accept;
  logic             we;
  logic [ID_W-1:0]  waddr;
  logic [CNT_W-1:0] wdata;

  assign amt_z = CNT_W'(msg.amount);

  always_comb begin
    sum     = {1'b0, old_val} + {1'b0, amt_z};
    ovf     = 1'b0;
    unf     = 1'b0;
    new_val = '0;
    if (msg.kind == CANCEL_ADD) begin
      ovf     = sum[CNT_W];
      new_val = ovf ? '1 : sum[CNT_W-1:0];
    end else begin
      unf     = amt_z > old_val;
      new_val = unf ? '0 : old_val - amt_z;
    end
  end

  // clear_all wins over a simultaneous message in any accepting state.
  assign in_ready = (state == IDLE || state == WRITE) && !bus.clear_all;
  assign accept   = bus.in_valid && in_ready;

  // Writes are suppressed under reset so an in-flight message is dropped.
  assign we    = !HRESET && (state == CLEAR || state == WRITE);
  assign waddr = (state == CLEAR) ? clr_cnt : msg.client_id;
  assign wdata = (state == CLEAR) ? '0 : new_val;

  cancel_table_ram u_ram (
    .clk     (clk),
    .rst     (HRESET),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re_a    (state == READ),
    .raddr_a (msg.client_id),
    .rdata_a (old_val),
    .raddr_b (bus.rd_client_id),
    .rdata_b (bus.rd_cancelled)
  );

  always_ff @(posedge clk) begin
    if (HRESET) begin
      state         <= CLEAR;
      clr_cnt       <= '0;
      msg           <= '0;
      sat_err       <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ID_W'(N_CLIENTS-1)) state <= IDLE;
        end
        IDLE: begin
          if (bus.clear_all) begin
            state         <= CLEAR;
            clr_cnt       <= '0;
            sat_err       <= 1'b0;
            underflow_err <= 1'b0;
          end else if (accept) begin
            msg   <= '{client_id: bus.in_client_id, amount: bus.in_amount, kind: bus.in_kind};
            state <= READ;
          end
        end
        READ: state <= WRITE;
        default: begin // WRITE
          sat_err       <= sat_err | ovf;
          underflow_err <= underflow_err | unf;
          if (bus.clear_all) begin
            // Entry to CLEAR wipes the flags, including any set by this write.
            state         <= CLEAR;
            clr_cnt       <= '0;
            sat_err       <= 1'b0;
            underflow_err <= 1'b0;
          end else if (accept) begin
            msg   <= '{client_id: bus.in_client_id, amount: bus.in_amount, kind: bus.in_kind};
            state <= READ;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.busy          = (state != IDLE);
  assign bus.upd_valid     = (state == WRITE);
  assign bus.upd_client_id = msg.client_id;
  assign bus.upd_total     = (state == WRITE) ? new_val : '0;
  assign bus.sat_err       = sat_err;
  assign bus.underflow_err = underflow_err;
endmodule

// File: tb/tb_downstream_cancel_tracker.sv
module tb_downstream_cancel_tracker;
  import downstream_cancel_tracker_pkg::*;

  logic clk = 1'b0;
  logic HRESET = 1'b1;
  always #5 clk = ~clk;

  downstream_cancel_tracker_if bus();

  downstream_cancel_tracker dut (
    .clk    (clk),
    .HRESET (HRESET),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_msg(input logic [ID_W-1:0] id, input logic [AMT_W-1:0] amt, input logic kind);
    bus.in_valid = 1'b1; bus.in_client_id = id; bus.in_amount = amt; bus.in_kind = kind;
  endtask

  // From IDLE: accept, READ, capture WRITE-cycle outputs, return in IDLE.
  task automatic send(input logic [ID_W-1:0] id, input logic [AMT_W-1:0] amt, input logic kind,
                      output logic [CNT_W-1:0] tot, output logic uv, output logic [ID_W-1:0] uid);
    drive_msg(id, amt, kind);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tot = bus.upd_total; uv = bus.upd_valid; uid = bus.upd_client_id;
    tick();
  endtask

  task automatic lookup(input logic [ID_W-1:0] id, output logic [CNT_W-1:0] val);
    bus.rd_client_id = id;
    tick();
    val = bus.rd_cancelled;
  endtask

  task automatic wait_ready(output int n, output logic saw_upd);
    n = 0; saw_upd = 1'b0;
    while (!bus.in_ready && n < 40) begin
      tick(); n++;
      if (bus.upd_valid) saw_upd = 1'b1;
    end
  endtask

  task automatic test_reset();
    int n; logic su; logic [CNT_W-1:0] v;
    HRESET = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %0b want 0", bus.in_ready); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy got %0b want 1", bus.busy); end
    n_cmp++; if (bus.upd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_upd_valid got %0b want 0", bus.upd_valid); end
    n_cmp++; if (bus.upd_client_id !== '0) begin n_bad++; $display("FAIL rst_upd_id got %0d want 0", bus.upd_client_id); end
    n_cmp++; if (bus.upd_total !== '0) begin n_bad++; $display("FAIL rst_upd_total got %0h want 0", bus.upd_total); end
    n_cmp++; if (bus.rd_cancelled !== '0) begin n_bad++; $display("FAIL rst_rd got %0h want 0", bus.rd_cancelled); end
    n_cmp++; if (bus.sat_err !== 1'b0) begin n_bad++; $display("FAIL rst_sat got %0b want 0", bus.sat_err); end
    n_cmp++; if (bus.underflow_err !== 1'b0) begin n_bad++; $display("FAIL rst_unf got %0b want 0", bus.underflow_err); end
    HRESET = 1'b0;
    wait_ready(n, su);
    n_cmp++; if (n != 32) begin n_bad++; $display("FAIL sweep_len got %0d want 32", n); end
    n_cmp++; if (su !== 1'b0) begin n_bad++; $display("FAIL sweep_upd got %0b want 0", su); end
    for (int i = 0; i < N_CLIENTS; i++) begin
      lookup(ID_W'(i), v);
      n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL init_lookup id %0d got %0h want 0", i, v); end
    end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] v;
    drive_msg(5'd3, 16'd100, CANCEL_ADD);
    tick();                                   // accepted, READ
    drive_msg(5'd3, 16'd50, CANCEL_ADD);
    tick();                                   // WRITE of first
    n_cmp++; if (bus.upd_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_v1 got %0b want 1", bus.upd_valid); end
    n_cmp++; if (bus.upd_client_id !== 5'd3) begin n_bad++; $display("FAIL b2b_id1 got %0d want 3", bus.upd_client_id); end
    n_cmp++; if (bus.upd_total !== 32'd100) begin n_bad++; $display("FAIL b2b_tot1 got %0d want 100", bus.upd_total); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %0b want 1", bus.in_ready); end
    tick();                                   // second accepted, READ
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.upd_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap got %0b want 0", bus.upd_valid); end
    tick();                                   // WRITE of second
    n_cmp++; if (bus.upd_total !== 32'd150) begin n_bad++; $display("FAIL b2b_tot2 got %0d want 150", bus.upd_total); end
    tick();
    lookup(5'd3, v);
    n_cmp++; if (v !== 32'd150) begin n_bad++; $display("FAIL b2b_lookup got %0d want 150", v); end
  endtask

  task automatic test_underflow();
    logic [CNT_W-1:0] t; logic uv; logic [ID_W-1:0] uid; logic [CNT_W-1:0] v;
    send(5'd7, 16'd4, CANCEL_ADD, t, uv, uid);
    n_cmp++; if (t !== 32'd4) begin n_bad++; $display("FAIL unf_pre got %0d want 4", t); end
    send(5'd7, 16'd10, CANCEL_SUB, t, uv, uid);
    n_cmp++; if (t !== 32'd0) begin n_bad++; $display("FAIL unf_tot got %0d want 0", t); end
    n_cmp++; if (bus.underflow_err !== 1'b1) begin n_bad++; $display("FAIL unf_flag got %0b want 1", bus.underflow_err); end
    n_cmp++; if (bus.sat_err !== 1'b0) begin n_bad++; $display("FAIL unf_sat got %0b want 0", bus.sat_err); end
    send(5'd7, 16'd0, CANCEL_SUB, t, uv, uid);
    n_cmp++; if (t !== 32'd0 || uv !== 1'b1 || uid !== 5'd7) begin n_bad++; $display("FAIL unf_zero got %0d/%0b/%0d want 0/1/7", t, uv, uid); end
    n_cmp++; if (bus.underflow_err !== 1'b1) begin n_bad++; $display("FAIL unf_sticky got %0b want 1", bus.underflow_err); end
    lookup(5'd7, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL unf_lookup got %0d want 0", v); end
  endtask

  task automatic test_saturate();
    logic [CNT_W-1:0] t; logic uv; logic [ID_W-1:0] uid; logic [CNT_W-1:0] v;
    // Reaching the top of a 32-bit counter with 16-bit adds takes ~64k
    // messages, so seed most of the way and finish with real adds.
    dut.u_ram.mem[31] <= 32'hFFFF_FFE0;
    tick();
    send(5'd31, 16'h0010, CANCEL_ADD, t, uv, uid);
    n_cmp++; if (t !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL sat_pre got %0h want fffffff0", t); end
    n_cmp++; if (bus.sat_err !== 1'b0) begin n_bad++; $display("FAIL sat_pre_flag got %0b want 0", bus.sat_err); end
    send(5'd31, 16'h0020, CANCEL_ADD, t, uv, uid);
    n_cmp++; if (t !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_tot got %0h want ffffffff", t); end
    n_cmp++; if (bus.sat_err !== 1'b1) begin n_bad++; $display("FAIL sat_flag got %0b want 1", bus.sat_err); end
    lookup(5'd31, v);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_lookup got %0h want ffffffff", v); end
  endtask

  task automatic test_clear_in_write();
    int n; logic su; logic [CNT_W-1:0] v;
    drive_msg(5'd2, 16'd9, CANCEL_ADD);
    tick();                                   // READ of msg to 2
    drive_msg(5'd4, 16'd5, CANCEL_ADD);
    tick();                                   // WRITE of msg to 2
    n_cmp++; if (bus.upd_valid !== 1'b1 || bus.upd_total !== 32'd9) begin n_bad++; $display("FAIL clr_write got %0b/%0d want 1/9", bus.upd_valid, bus.upd_total); end
    bus.clear_all = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL clr_ready got %0b want 0", bus.in_ready); end
    tick();
    bus.clear_all = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL clr_state got busy %0b ready %0b want 1/0", bus.busy, bus.in_ready); end
    n_cmp++; if (bus.sat_err !== 1'b0 || bus.underflow_err !== 1'b0) begin n_bad++; $display("FAIL clr_flags got %0b/%0b want 0/0", bus.sat_err, bus.underflow_err); end
    wait_ready(n, su);
    n_cmp++; if (n != 32) begin n_bad++; $display("FAIL clr_len got %0d want 32", n); end
    n_cmp++; if (su !== 1'b0) begin n_bad++; $display("FAIL clr_upd got %0b want 0", su); end
    tick();                                   // pending msg to 4 accepted
    bus.in_valid = 1'b0;
    tick();
    n_cmp++; if (bus.upd_valid !== 1'b1 || bus.upd_client_id !== 5'd4 || bus.upd_total !== 32'd5) begin
      n_bad++; $display("FAIL clr_pending got %0b/%0d/%0d want 1/4/5", bus.upd_valid, bus.upd_client_id, bus.upd_total); end
    tick();
    lookup(5'd2, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL clr_lookup2 got %0d want 0", v); end
    lookup(5'd31, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL clr_lookup31 got %0h want 0", v); end
  endtask

  task automatic test_reset_mid();
    int n; logic su; logic [CNT_W-1:0] v;
    drive_msg(5'd5, 16'd77, CANCEL_ADD);
    tick();                                   // READ of msg to 5
    bus.in_valid = 1'b0;
    HRESET = 1'b1;
    tick();
    n_cmp++; if (bus.upd_valid !== 1'b0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_rst got upd %0b busy %0b want 0/1", bus.upd_valid, bus.busy); end
    HRESET = 1'b0;
    wait_ready(n, su);
    n_cmp++; if (su !== 1'b0) begin n_bad++; $display("FAIL mid_upd got %0b want 0", su); end
    n_cmp++; if (n != 32) begin n_bad++; $display("FAIL mid_len got %0d want 32", n); end
    lookup(5'd5, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL mid_lookup5 got %0d want 0", v); end
    lookup(5'd4, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL mid_lookup4 got %0d want 0", v); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_client_id = '0; bus.in_amount = '0; bus.in_kind = 1'b0;
    bus.clear_all = 1'b0; bus.rd_client_id = '0;
    test_reset();
    test_back_to_back();
    test_underflow();
    test_saturate();
    test_clear_in_write();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
